// File: rtl/mult_seq_pkg.sv
// Shared definitions for mult_seq and other initiators of the shared ALU:
// ALU control encodings, the multiplier state enum, and the ALU drive payload.
package mult_seq_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_BITS   = 6;
    localparam int unsigned GIN_W      = 3;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned ITERATIONS = 32;

    // ALU control line encodings
    localparam logic [GIN_W-1:0] ALU_AND = 3'b000;
    localparam logic [GIN_W-1:0] ALU_OR  = 3'b001;
    localparam logic [GIN_W-1:0] ALU_ADD = 3'b010;
    localparam logic [GIN_W-1:0] ALU_SRL = 3'b100;
    localparam logic [GIN_W-1:0] ALU_SUB = 3'b110;
    localparam logic [GIN_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operand/control payload driven onto the shared ALU
    typedef struct packed {
        logic [GIN_W-1:0]  gin;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_drv_t;

    localparam alu_drv_t ALU_DRV_IDLE = '{gin: ALU_ADD, a: '0, b: '0};

endpackage

// File: rtl/mult_seq.sv
// mult_seq: iterative 32x32 unsigned shift-add multiplier that borrows the
// shared combinational ALU for its additions.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   mcand, mplier         operands, sampled on accept
//   done                  one-cycle pulse, product valid
//   busy                  high from CHECK through DONE
//   prod_hi, prod_lo      64-bit product, held from DONE until next accept
//   alu_a/alu_b/alu_gin   ALU operand and control drive
//   alu_shamt             ALU shift amount, tied to zero
//   alu_sum, alu_zout     ALU result and zero flag
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned CNT_W = CNT_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               done,
    output logic               busy,
    output logic [WIDTH-1:0]   prod_hi,
    output logic [WIDTH-1:0]   prod_lo,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [GIN_W-1:0]   alu_gin,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [WIDTH-1:0]   alu_sum,
    input  logic               alu_zout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] mcand_r, mcand_nxt;
    logic [WIDTH-1:0] prod_hi_nxt, prod_lo_nxt;
    logic             done_nxt, busy_nxt, req_ready_nxt;
    logic             carry;
    alu_drv_t         alu_r, alu_nxt;

    // Next-state, datapath and ALU-drive computation
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mcand_nxt   = mcand_r;
        prod_hi_nxt = prod_hi;
        prod_lo_nxt = prod_lo;
        carry       = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    mcand_nxt   = mcand;
                    prod_hi_nxt = '0;
                    prod_lo_nxt = mplier;
                    cnt_nxt     = '0;
                    state_nxt   = CHECK;
                end
            end
            CHECK: begin
                // ALU is ORing the multiplier with zero: zero flag means 0 product
                if (alu_zout) begin
                    prod_hi_nxt = '0;
                    prod_lo_nxt = '0;
                    state_nxt   = DONE;
                end else begin
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                // ALU drops the carry-out; a wrapped sum is smaller than its addend
                carry       = (alu_sum < prod_hi);
                prod_hi_nxt = {carry, alu_sum[WIDTH-1:1]};
                prod_lo_nxt = {alu_sum[0], prod_lo[WIDTH-1:1]};
                cnt_nxt     = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        done_nxt      = (state_nxt == DONE);
        busy_nxt      = (state_nxt != IDLE);
        req_ready_nxt = (state_nxt == IDLE);

        // ALU drive is registered, so it is derived from the upcoming state
        alu_nxt = ALU_DRV_IDLE;
        case (state_nxt)
            CHECK: begin
                alu_nxt.gin = ALU_OR;
                alu_nxt.a   = prod_lo_nxt;
                alu_nxt.b   = '0;
            end
            RUN: begin
                alu_nxt.gin = ALU_ADD;
                alu_nxt.a   = prod_hi_nxt;
                alu_nxt.b   = prod_lo_nxt[0] ? mcand_nxt : '0;
            end
            default: begin
                alu_nxt = ALU_DRV_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand_r   <= '0;
            prod_hi   <= '0;
            prod_lo   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            alu_r     <= ALU_DRV_IDLE;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mcand_r   <= mcand_nxt;
            prod_hi   <= prod_hi_nxt;
            prod_lo   <= prod_lo_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            req_ready <= req_ready_nxt;
            alu_r     <= alu_nxt;
        end
    end

    assign alu_a     = alu_r.a;
    assign alu_b     = alu_r.b;
    assign alu_gin   = alu_r.gin;
    assign alu_shamt = '0;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq with an attached combinational ALU and a timing/product
// model derived from operand arithmetic.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;
    logic        done, busy;
    logic [31:0] prod_hi, prod_lo;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_gin;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_sum;
    logic        alu_zout;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .done      (done),
        .busy      (busy),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_gin   (alu_gin),
        .alu_shamt (alu_shamt),
        .alu_sum   (alu_sum),
        .alu_zout  (alu_zout)
    );

    // Shared processor ALU
    always_comb begin
        case (alu_gin)
            3'b000:  alu_sum = alu_a & alu_b;
            3'b001:  alu_sum = alu_a | alu_b;
            3'b010:  alu_sum = alu_a + alu_b;
            3'b100:  alu_sum = alu_b >> alu_shamt;
            3'b110:  alu_sum = alu_a - alu_b;
            3'b111:  alu_sum = {31'd0, (alu_a < alu_b)};
            default: alu_sum = '0;
        endcase
    end
    assign alu_zout = (alu_sum == 32'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a request is served after a fixed number of cycles and
    // yields the arithmetic product of the operands
    bit          m_busy = 0, m_done = 0, m_first = 0;
    int          m_rem = 0;
    logic [63:0] m_prod = '0, m_pend = '0;
    logic [31:0] m_mp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_first = 0; m_rem = 0; m_prod = '0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_first = 0;
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1;
                m_prod = m_pend;
            end
        end else if (req_valid) begin
            m_busy  = 1;
            m_first = 1;
            m_rem   = (mplier == 32'd0) ? 1 : 33;
            m_pend  = 64'(mcand) * 64'(mplier);
            m_mp    = mplier;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("req_ready", 64'(req_ready), 64'(!m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("alu_shamt", 64'(alu_shamt), 64'd0);
        if (!m_busy || m_done)
            chk("product", {prod_hi, prod_lo}, m_prod);
        if (!m_busy) begin
            chk("idle_gin", 64'(alu_gin), 64'(3'b010));
            chk("idle_a", 64'(alu_a), 64'd0);
            chk("idle_b", 64'(alu_b), 64'd0);
        end else if (m_first) begin
            chk("check_gin", 64'(alu_gin), 64'(3'b001));
            chk("check_a", 64'(alu_a), 64'(m_mp));
            chk("check_b", 64'(alu_b), 64'd0);
        end else if (!m_done) begin
            chk("run_gin", 64'(alu_gin), 64'(3'b010));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
    endtask

    // Issue one request; returns at the negedge of the CHECK cycle
    task automatic start(input logic [31:0] mc, input logic [31:0] mp);
        wait_ready();
        mcand     = mc;
        mplier    = mp;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // lat counts cycles after the accept edge (CHECK cycle is 1)
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] mc, input logic [31:0] mp,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
        int lat;
        start(mc, mp);
        chk({name, "_check_gin"}, 64'(alu_gin), 64'(3'b001));
        wait_done(lat);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_hi"}, 64'(prod_hi), 64'(exp_hi));
        chk({name, "_lo"}, 64'(prod_lo), 64'(exp_lo));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] mc, mp;
        logic [63:0] p;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
        chk("rst_gin", 64'(alu_gin), 64'(3'b010));
        chk("rst_a", 64'(alu_a), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic", 32'd3, 32'd5, 32'h0, 32'hF, 34);
        run_op("zero_mplier", 32'h1234, 32'd0, 32'h0, 32'h0, 2);
        run_op("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34);
        run_op("msb_x2", 32'h8000_0000, 32'd2, 32'h1, 32'h0, 34);
        run_op("one_x", 32'd1, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 34);
        run_op("zero_mcand", 32'd0, 32'h1234_5678, 32'h0, 32'h0, 34);

        // Requests held high during a run are ignored until IDLE
        wait_ready();
        mcand = 32'h0001_0000; mplier = 32'h0001_0000; req_valid = 1'b1;
        @(negedge clk);
        mcand = 32'h1111_1111; mplier = 32'h0000_000F;
        wait_done(lat);
        chk("hold1_lat", 64'(lat), 64'd34);
        chk("hold1_hi", 64'(prod_hi), 64'h1);
        chk("hold1_lo", 64'(prod_lo), 64'h0);
        @(negedge clk);
        chk("hold_idle_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold2_accepted", 64'(busy), 64'd1);
        wait_done(lat);
        chk("hold2_lat", 64'(lat), 64'd34);
        chk("hold2_hi", 64'(prod_hi), 64'h0);
        chk("hold2_lo", 64'(prod_lo), 64'hFFFF_FFFF);
        @(negedge clk);

        // Reset while iterating at cnt=10
        start(32'h1234, 32'h5678);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_prod", {prod_hi, prod_lo}, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 32'd7, 32'd6, 32'h0, 32'd42, 34);

        // Random operands, product from plain arithmetic
        for (int i = 0; i < 30; i++) begin
            mc = $urandom;
            mp = $urandom;
            if ($urandom_range(0, 7) == 0) mp = '0;
            if ($urandom_range(0, 7) == 0) mc = '0;
            p = 64'(mc) * 64'(mp);
            start(mc, mp);
            wait_done(lat);
            chk("rand_lat", 64'(lat), (mp == 32'd0) ? 64'd2 : 64'd34);
            chk("rand_prod", {prod_hi, prod_lo}, p);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
